// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace unit: stream tags, serializer
// states and record-width helpers.
package trace_pkg;

   localparam logic [1:0] TAG_PC    = 2'd0;
   localparam logic [1:0] TAG_INSTR = 2'd1;
   localparam logic [1:0] TAG_HDR   = 2'd2;
   localparam logic [1:0] TAG_DATA  = 2'd3;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_RIDX_W = 5;

   // A record is {pc, instr, wb_seen, wb_idx, wb_data}
   localparam int REC_W = 3*DEF_DATA_W + DEF_RIDX_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      S_PC,
      S_INSTR,
      S_HDR,
      S_DATA
   } ser_state_t;

   // Record width for non-default parameterisations of the tracer
   function automatic int recWidth(input int dataW, input int ridxW);
      return 3*dataW + ridxW + 1;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO for the commit tracer. Pointers carry one extra bit so that
// full and empty can be told apart; a push while full is accepted when a
// pop happens in the same cycle. Exposes both the head entry and the entry
// behind it so the serializer can chain records without a bubble.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int WIDTH = REC_W,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_pushData,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_headData,
   output logic [WIDTH-1:0]         o_nextData,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] IDX_ONE = AW'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic             w_pushOk;
   logic             w_popOk;
   logic [AW-1:0]    w_rdIdxNext;

   assign o_count     = r_wrPtr - r_rdPtr;
   assign o_empty     = (r_wrPtr == r_rdPtr);
   assign o_full      = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                        (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign w_popOk     = i_pop & ~o_empty;
   assign w_pushOk    = i_push & (~o_full | w_popOk);
   assign w_rdIdxNext = r_rdPtr[AW-1:0] + IDX_ONE;
   assign o_headData  = r_mem[r_rdPtr[AW-1:0]];
   assign o_nextData  = r_mem[w_rdIdxNext];

   // Storage array; contents need no reset because the pointers gate reads
   always_ff @(posedge i_clk) begin
      if (w_pushOk) begin
         r_mem[r_wrPtr[AW-1:0]] <= i_pushData;
      end
   end

   // Read and write pointers wrap naturally modulo 2*DEPTH
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_pushOk) begin
            r_wrPtr <= r_wrPtr + PTR_ONE;
         end
         if (w_popOk) begin
            r_rdPtr <= r_rdPtr + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/commit_trace_unit.sv
// Retirement tracer: detects commits on the rising edge of instr_change,
// bundles PC, instruction and the last register writeback into a record,
// buffers it and streams it out as four tagged words (PC, INSTR, HDR, DATA).
// Optional build macro TRACE_PC_FILTER_EN adds filter_lo/filter_hi ports and
// only records commits whose PC lies inside [filter_lo, filter_hi].
module commit_trace_unit
   import trace_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RIDX_W = 5,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              trace_en,
   input  logic              instr_change,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [DATA_W-1:0] instr_in,
   input  logic              rf_we,
   input  logic [RIDX_W-1:0] rf_waddr,
   input  logic [DATA_W-1:0] rf_wdata,
`ifdef TRACE_PC_FILTER_EN
   input  logic [DATA_W-1:0] filter_lo,
   input  logic [DATA_W-1:0] filter_hi,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        out_tag,
   output logic              out_last,
   output logic              overflow,
   output logic [CNT_W-1:0]  commit_count,
   output logic [CNT_W-1:0]  drop_count
);

   localparam int REC_W_L = recWidth(DATA_W, RIDX_W);
   localparam int HOLD_W  = REC_W_L - DATA_W;
   localparam int AW      = $clog2(DEPTH);
   localparam int HDR_PAD = DATA_W - 1 - RIDX_W;
   localparam logic [AW:0]      CNT_ONE_REC = (AW+1)'(1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   // Commit detection and writeback accumulator
   logic              r_icQ;
   logic              r_accSeen;
   logic [RIDX_W-1:0] r_accIdx;
   logic [DATA_W-1:0] r_accData;
   logic              w_commit;
   logic              w_wrValid;
   logic              w_wbSeen;
   logic [RIDX_W-1:0] w_wbIdx;
   logic [DATA_W-1:0] w_wbData;
   logic              w_pcPass;

   // FIFO interface
   logic               w_push;
   logic               w_pop;
   logic               w_drop;
   logic               w_full;
   logic               w_empty;
   logic [AW:0]        w_count;
   logic [REC_W_L-1:0] w_pushRec;
   logic [REC_W_L-1:0] w_headRec;
   logic [REC_W_L-1:0] w_nextFifoRec;
   logic [REC_W_L-1:0] w_nextRec;
   logic               w_nextAvail;

   // Serializer; the PC is presented straight into out_data on load, so the
   // holding register only keeps the remaining fields
   ser_state_t        r_state;
   logic [HOLD_W-1:0] r_hold;
   logic [DATA_W-1:0] w_holdInstr;
   logic              w_holdSeen;
   logic [RIDX_W-1:0] w_holdIdx;
   logic [DATA_W-1:0] w_holdWb;
   logic [DATA_W-1:0] w_hdrWord;
   logic [DATA_W-1:0] w_dataWord;

   assign w_commit  = instr_change & ~r_icQ;
   assign w_wrValid = rf_we & (rf_waddr != '0);

   // A write in the commit cycle itself is folded into the retiring record
   assign w_wbSeen  = w_wrValid | r_accSeen;
   assign w_wbIdx   = w_wrValid ? rf_waddr : r_accIdx;
   assign w_wbData  = w_wrValid ? rf_wdata : r_accData;

`ifdef TRACE_PC_FILTER_EN
   assign w_pcPass = (pc_in >= filter_lo) && (pc_in <= filter_hi);
`else
   assign w_pcPass = 1'b1;
`endif

   assign w_push    = w_commit & trace_en & w_pcPass;
   assign w_pushRec = {pc_in, instr_in, w_wbSeen, w_wbIdx, w_wbData};
   assign w_pop     = (r_state == S_DATA) & out_ready;
   assign w_drop    = w_push & w_full & ~w_pop;

   // When exactly one record remains and it is being popped, a same-cycle
   // push supplies the follow-on record directly so the stream has no gap
   assign w_nextAvail = (w_count > CNT_ONE_REC) ||
                        ((w_count == CNT_ONE_REC) && w_push);
   assign w_nextRec   = (w_count > CNT_ONE_REC) ? w_nextFifoRec : w_pushRec;

   assign w_holdWb    = r_hold[DATA_W-1:0];
   assign w_holdIdx   = r_hold[DATA_W +: RIDX_W];
   assign w_holdSeen  = r_hold[DATA_W+RIDX_W];
   assign w_holdInstr = r_hold[DATA_W+RIDX_W+1 +: DATA_W];
   assign w_hdrWord   = {w_holdSeen, {HDR_PAD{1'b0}}, w_holdIdx};
   assign w_dataWord  = w_holdSeen ? w_holdWb : '0;

   trace_fifo #(
      .WIDTH (REC_W_L),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk      (clk_in),
      .i_reset    (reset),
      .i_push     (w_push),
      .i_pushData (w_pushRec),
      .i_pop      (w_pop),
      .o_headData (w_headRec),
      .o_nextData (w_nextFifoRec),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

   // One-cycle history of instr_change for rising-edge commit detection
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_icQ <= 1'b0;
      end else begin
         r_icQ <= instr_change;
      end
   end

   // Last nonzero-index writeback since the previous commit; restarts after each commit
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_accSeen <= 1'b0;
         r_accIdx  <= '0;
         r_accData <= '0;
      end else if (w_commit) begin
         r_accSeen <= 1'b0;
         r_accIdx  <= '0;
         r_accData <= '0;
      end else if (w_wrValid) begin
         r_accSeen <= 1'b1;
         r_accIdx  <= rf_waddr;
         r_accData <= rf_wdata;
      end
   end

   // Commit counter wraps, drop counter saturates, overflow is sticky until reset
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         commit_count <= '0;
         drop_count   <= '0;
         overflow     <= 1'b0;
      end else begin
         if (w_commit) begin
            commit_count <= commit_count + CNT_ONE;
         end
         if (w_drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
               drop_count <= drop_count + CNT_ONE;
            end
         end
      end
   end

   // Serializer: loads the head record, walks PC/INSTR/HDR/DATA on each
   // handshake, pops on the DATA handshake and chains straight into the next record
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_hold    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= TAG_PC;
         out_last  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_state   <= S_PC;
                  r_hold    <= w_headRec[HOLD_W-1:0];
                  out_valid <= 1'b1;
                  out_data  <= w_headRec[HOLD_W +: DATA_W];
                  out_tag   <= TAG_PC;
                  out_last  <= 1'b0;
               end
            end
            S_PC: begin
               if (out_ready) begin
                  r_state  <= S_INSTR;
                  out_data <= w_holdInstr;
                  out_tag  <= TAG_INSTR;
               end
            end
            S_INSTR: begin
               if (out_ready) begin
                  r_state  <= S_HDR;
                  out_data <= w_hdrWord;
                  out_tag  <= TAG_HDR;
               end
            end
            S_HDR: begin
               if (out_ready) begin
                  r_state  <= S_DATA;
                  out_data <= w_dataWord;
                  out_tag  <= TAG_DATA;
                  out_last <= 1'b1;
               end
            end
            S_DATA: begin
               if (out_ready) begin
                  if (w_nextAvail) begin
                     r_state  <= S_PC;
                     r_hold   <= w_nextRec[HOLD_W-1:0];
                     out_data <= w_nextRec[HOLD_W +: DATA_W];
                     out_tag  <= TAG_PC;
                     out_last <= 1'b0;
                  end else begin
                     r_state   <= IDLE;
                     out_valid <= 1'b0;
                     out_data  <= '0;
                     out_tag   <= TAG_PC;
                     out_last  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_commit_trace_unit.sv
// Self-checking bench for commit_trace_unit: table-driven single-record
// vectors, hand-written corner sequences and a randomized phase checked
// against a record-level reference model. Build with TRACE_PC_FILTER_EN to
// also exercise the PC window filter.
`timescale 1ns/1ps
module tb_commit_trace_unit;

   localparam int DEPTH = 16;

   logic        clk_in = 1'b0;
   logic        reset;
   logic        trace_en;
   logic        instr_change;
   logic [31:0] pc_in;
   logic [31:0] instr_in;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
`ifdef TRACE_PC_FILTER_EN
   logic [31:0] filter_lo;
   logic [31:0] filter_hi;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_tag;
   logic        out_last;
   logic        overflow;
   logic [15:0] commit_count;
   logic [15:0] drop_count;

   commit_trace_unit #(
      .DATA_W (32),
      .RIDX_W (5),
      .DEPTH  (DEPTH),
      .CNT_W  (16)
   ) dut (
      .clk_in       (clk_in),
      .reset        (reset),
      .trace_en     (trace_en),
      .instr_change (instr_change),
      .pc_in        (pc_in),
      .instr_in     (instr_in),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
`ifdef TRACE_PC_FILTER_EN
      .filter_lo    (filter_lo),
      .filter_hi    (filter_hi),
`endif
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_tag      (out_tag),
      .out_last     (out_last),
      .overflow     (overflow),
      .commit_count (commit_count),
      .drop_count   (drop_count)
   );

   // 100 MHz clock
   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        seen;
      logic [4:0]  idx;
      logic [31:0] data;
   } rec_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  tag;
      logic        last;
   } word_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      int          nWr;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic [31:0] expHdr;
      logic [31:0] expData;
   } vec_t;

   rec_t  expQ[$];
   word_t capQ[$];
   vec_t  vecs[5];

   int checks = 0;
   int fails  = 0;

   // Reference model state
   bit          mIcPrev;
   bit          mSeen;
   logic [4:0]  mIdx;
   logic [31:0] mData;
   int          mCommits;
   int          mDrops;
   bit          mOverflow;

   // Monitor state
   int    wIdx = 0;
   bit    prevStall = 0;
   word_t prevW;
   int    validCycles = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [34:0] expWord(input rec_t r, input int i);
      logic [31:0] hdr;
      hdr = (r.seen ? 32'h8000_0000 : 32'h0) | {27'b0, r.idx};
      case (i)
         0:       return {1'b0, 2'd0, r.pc};
         1:       return {1'b0, 2'd1, r.instr};
         2:       return {1'b0, 2'd2, hdr};
         default: return {1'b1, 2'd3, (r.seen ? r.data : 32'h0)};
      endcase
   endfunction

   // Drive one cycle of inputs, update the reference model, advance one clock
   task automatic applyStimulus(input bit ic, input bit we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [31:0] pc,
                                input logic [31:0] ir);
      bit commit;
      bit pass;
      rec_t r;
      instr_change = ic;
      rf_we        = we;
      rf_waddr     = wa;
      rf_wdata     = wd;
      pc_in        = pc;
      instr_in     = ir;
      commit  = ic && !mIcPrev;
      mIcPrev = ic;
      if (we && wa != 5'd0) begin
         mSeen = 1'b1;
         mIdx  = wa;
         mData = wd;
      end
      if (commit) begin
         mCommits++;
         pass = 1'b1;
`ifdef TRACE_PC_FILTER_EN
         pass = (pc >= filter_lo) && (pc <= filter_hi);
`endif
         if (trace_en && pass) begin
            if (expQ.size() >= DEPTH) begin
               mDrops++;
               mOverflow = 1'b1;
            end else begin
               r.pc = pc; r.instr = ir; r.seen = mSeen; r.idx = mIdx; r.data = mData;
               expQ.push_back(r);
            end
         end
         mSeen = 1'b0;
         mIdx  = 5'd0;
         mData = 32'h0;
      end
      @(posedge clk_in);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic commitOnce(input logic [31:0] pc, input logic [31:0] ir);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, pc, ir);
      idleCycle();
   endtask

   task automatic doReset();
      instr_change = 1'b0;
      rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'h0;
      pc_in = 32'h0; instr_in = 32'h0;
      reset = 1'b1;
      mIcPrev = 1'b0; mSeen = 1'b0; mIdx = 5'd0; mData = 32'h0;
      mCommits = 0; mDrops = 0; mOverflow = 1'b0;
      expQ.delete();
      repeat (2) @(posedge clk_in);
      #1;
      reset = 1'b0;
      capQ.delete();
      validCycles = 0;
   endtask

   task automatic waitWords(input int n, input int budget);
      int k;
      k = 0;
      while (capQ.size() < n && k < budget) begin
         idleCycle();
         k++;
      end
      checkOutput("wait_words_timeout", capQ.size() >= n, 1);
   endtask

   task automatic waitDrain(input int budget);
      int k;
      k = 0;
      while ((expQ.size() != 0 || wIdx != 0) && k < budget) begin
         idleCycle();
         k++;
      end
      checkOutput("drain_timeout", expQ.size(), 0);
   endtask

   // Stream monitor: checks stability under back-pressure and every accepted word against the model
   always @(negedge clk_in) begin
      if (reset) begin
         prevStall = 1'b0;
         wIdx = 0;
      end else begin
         if (prevStall) begin
            checkOutput("stall_stable", {out_valid, out_last, out_tag, out_data},
                        {1'b1, prevW.last, prevW.tag, prevW.data});
         end
         if (out_valid) validCycles++;
         if (out_valid && out_ready) begin
            capQ.push_back('{out_data, out_tag, out_last});
            if (expQ.size() == 0) begin
               checks++;
               fails++;
               $display("[TB] FAIL unexpected_word: actual 0x%08h tag %0d, required no word", out_data, out_tag);
            end else begin
               checkOutput("stream_word", {out_last, out_tag, out_data}, expWord(expQ[0], wIdx));
               if (wIdx == 3) begin
                  void'(expQ.pop_front());
                  wIdx = 0;
               end else begin
                  wIdx++;
               end
            end
         end
         prevStall = out_valid && !out_ready;
         prevW = '{out_data, out_tag, out_last};
      end
   end

   // Watchdog so the run always terminates
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: actual timeout, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int badTags;
      vecs[0] = '{32'h0040_0004, 32'h0001_1080, 1, 5'd2,  32'h0000_0010, 5'd0, 32'h0, 32'h8000_0002, 32'h0000_0010};
      vecs[1] = '{32'h0040_0008, 32'h0000_0013, 1, 5'd0,  32'h0000_DEAD, 5'd0, 32'h0, 32'h0000_0000, 32'h0000_0000};
      vecs[2] = '{32'h0040_000C, 32'h00A0_0193, 2, 5'd3,  32'h0000_0005, 5'd4, 32'h9, 32'h8000_0004, 32'h0000_0009};
      vecs[3] = '{32'h0040_0010, 32'h1234_5678, 0, 5'd0,  32'h0,         5'd0, 32'h0, 32'h0000_0000, 32'h0000_0000};
      vecs[4] = '{32'h0040_0014, 32'hCAFE_F00D, 2, 5'd31, 32'hFFFF_FFFF, 5'd0, 32'h1, 32'h8000_001F, 32'hFFFF_FFFF};

      reset = 1'b1;
      trace_en = 1'b1;
      out_ready = 1'b1;
      instr_change = 1'b0;
      rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'h0;
      pc_in = 32'h0; instr_in = 32'h0;
`ifdef TRACE_PC_FILTER_EN
      filter_lo = 32'h0;
      filter_hi = 32'hFFFF_FFFF;
`endif
      #3;
      checkOutput("reset_valid", out_valid, 0);
      checkOutput("reset_data", {out_last, out_tag, out_data}, 0);
      checkOutput("reset_counters", {overflow, commit_count, drop_count}, 0);
      doReset();

      // Table-driven single-record vectors
      for (int i = 0; i < 5; i++) begin
         capQ.delete();
         if (vecs[i].nWr >= 1) applyStimulus(1'b0, 1'b1, vecs[i].wa0, vecs[i].wd0, 32'h0, 32'h0);
         if (vecs[i].nWr >= 2) applyStimulus(1'b0, 1'b1, vecs[i].wa1, vecs[i].wd1, 32'h0, 32'h0);
         applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, vecs[i].pc, vecs[i].instr);
         waitWords(4, 20);
         if (capQ.size() >= 4) begin
            checkOutput("vec_pc",    {capQ[0].last, capQ[0].tag, capQ[0].data}, {1'b0, 2'd0, vecs[i].pc});
            checkOutput("vec_instr", {capQ[1].last, capQ[1].tag, capQ[1].data}, {1'b0, 2'd1, vecs[i].instr});
            checkOutput("vec_hdr",   {capQ[2].last, capQ[2].tag, capQ[2].data}, {1'b0, 2'd2, vecs[i].expHdr});
            checkOutput("vec_data",  {capQ[3].last, capQ[3].tag, capQ[3].data}, {1'b1, 2'd3, vecs[i].expData});
         end
         checkOutput("vec_commit_count", commit_count, i + 1);
      end

      // One-cycle latency from push to first word
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 32'h0040_0100, 32'h0000_0001);
      checkOutput("latency_wait", out_valid, 0);
      idleCycle();
      checkOutput("latency_first", {out_valid, out_tag, out_data}, {1'b1, 2'd0, 32'h0040_0100});
      waitDrain(40);

      // A write in the commit cycle belongs to that record; the next cycle's write to the next one
      capQ.delete();
      applyStimulus(1'b1, 1'b1, 5'd5, 32'h7, 32'h0040_0200, 32'h0000_0002);
      applyStimulus(1'b0, 1'b1, 5'd6, 32'h8, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 32'h0040_0204, 32'h0000_0003);
      idleCycle();
      waitDrain(40);
      checkOutput("commit_cycle_write_words", capQ.size(), 8);
      if (capQ.size() >= 8) begin
         checkOutput("commit_cycle_hdr0", {capQ[2].data, capQ[3].data}, {32'h8000_0005, 32'h7});
         checkOutput("commit_cycle_hdr1", {capQ[6].data, capQ[7].data}, {32'h8000_0006, 32'h8});
      end

      // FIFO full with the sink stalled, then a full drain
      doReset();
      out_ready = 1'b0;
      for (int i = 0; i < 20; i++) commitOnce(32'h0000_1000 + 32'(i * 4), 32'h0100_0000 + 32'(i));
      checkOutput("full_overflow", overflow, 1);
      checkOutput("full_drop_count", drop_count, 4);
      checkOutput("full_commit_count", commit_count, 20);
      checkOutput("full_held_word", {out_valid, out_tag, out_data}, {1'b1, 2'd0, 32'h0000_1000});
      capQ.delete();
      out_ready = 1'b1;
      waitDrain(200);
      checkOutput("full_drain_words", capQ.size(), 64);
      badTags = 0;
      foreach (capQ[k]) if (capQ[k].tag != 2'(k % 4)) badTags++;
      checkOutput("full_tag_cycle", badTags, 0);
      checkOutput("full_sticky", {overflow, drop_count}, {1'b1, 16'd4});

      // Held strobe counts once; disabled tracing still counts commits but emits nothing
      doReset();
      trace_en = 1'b0;
      repeat (10) applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 32'h0040_0000, 32'h0);
      checkOutput("held_commit_count", commit_count, 1);
      for (int i = 0; i < 8; i++) begin
         idleCycle();
         idleCycle();
         applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 32'h0040_0000, 32'h0);
         applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 32'h0040_0000, 32'h0);
      end
      idleCycle();
      checkOutput("toggle_commit_count", commit_count, 9);
      checkOutput("disabled_no_valid", validCycles, 0);
      trace_en = 1'b1;

      // Asynchronous reset while the serializer sits on the HDR word with three records queued
      doReset();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) commitOnce(32'h0000_2000 + 32'(i * 4), 32'h0200_0000 + 32'(i));
      repeat (2) idleCycle();
      out_ready = 1'b1;
      repeat (2) idleCycle();
      out_ready = 1'b0;
      checkOutput("pre_reset_hdr", {out_valid, out_tag}, {1'b1, 2'd2});
      reset = 1'b1;
      #1;
      checkOutput("async_reset_valid", out_valid, 0);
      checkOutput("async_reset_counters", {overflow, commit_count, drop_count}, 0);
      doReset();
      out_ready = 1'b1;
      repeat (20) idleCycle();
      checkOutput("post_reset_no_words", capQ.size(), 0);
      checkOutput("post_reset_no_valid", validCycles, 0);

      // Randomized traffic against the reference model
      doReset();
      for (int i = 0; i < 600; i++) begin
         bit ic;
         out_ready = ($urandom % 4) != 0;
         trace_en  = ($urandom % 8) != 0;
         ic = ($urandom % 2) == 1;
         if (expQ.size() >= DEPTH - 4) ic = 1'b0;
         applyStimulus(ic, ($urandom % 2) == 1, 5'($urandom % 32), $urandom, $urandom, $urandom);
      end
      out_ready = 1'b1;
      trace_en = 1'b1;
      waitDrain(400);
      checkOutput("rand_commit_count", commit_count, 16'(mCommits));
      checkOutput("rand_no_drop", {overflow, drop_count}, {mOverflow, 16'(mDrops)});

`ifdef TRACE_PC_FILTER_EN
      // PC window filter
      doReset();
      filter_lo = 32'h0040_0010;
      filter_hi = 32'h0040_0020;
      commitOnce(32'h0040_000C, 32'h1);
      commitOnce(32'h0040_0010, 32'h2);
      commitOnce(32'h0040_0024, 32'h3);
      waitDrain(60);
      checkOutput("filter_words", capQ.size(), 4);
      if (capQ.size() >= 1) checkOutput("filter_pc", capQ[0].data, 32'h0040_0010);
      checkOutput("filter_counts", {commit_count, drop_count}, {16'd3, 16'd0});
      filter_lo = 32'h0;
      filter_hi = 32'hFFFF_FFFF;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
